// File: rtl/starship_pkg.sv
// Shared colour constants and shield state encoding for the starship display.
package starship_pkg;

    // 12-bit RGB colours, 4 bits per channel
    localparam logic [11:0] BLACK      = 12'h000;
    localparam logic [11:0] GREY       = 12'hCCC;
    localparam logic [11:0] LIGHT_BLUE = 12'h9DF;
    localparam logic [11:0] PINK       = 12'hF88;
    localparam logic [11:0] BACKGROUND = 12'h015;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } shield_state_t;

endpackage

// File: rtl/shield_fsm.sv
// Timed shield controller: READY -> ACTIVE -> COOLDOWN -> READY, counted in move_ticks.
module shield_fsm
    import starship_pkg::*;
#(
    parameter int SHIELD_TICKS   = 120,
    parameter int COOLDOWN_TICKS = 60,
    parameter int BLINK_TICKS    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic move_tick,
    input  logic shield_req,
    output logic shield_active,
    output logic shield_ready,
    output logic shield_visible
);

    localparam int MAX_TICKS = (SHIELD_TICKS > COOLDOWN_TICKS) ? SHIELD_TICKS : COOLDOWN_TICKS;
    // At least 3 bits so the blink phase bit always exists
    localparam int CW = ($clog2(MAX_TICKS + 1) < 3) ? 3 : $clog2(MAX_TICKS + 1);

    shield_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q;
    logic          req_edge;

    assign req_edge = shield_req & ~req_q;

    // State, counter and request-edge registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READY;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= shield_req;
        end
    end

    // Next-state logic; a request edge in READY wins over a coincident tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            READY: begin
                if (req_edge) begin
                    state_d = ACTIVE;
                    cnt_d   = CW'(SHIELD_TICKS);
                end
            end
            ACTIVE: begin
                if (move_tick) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = COOLDOWN;
                        cnt_d   = CW'(COOLDOWN_TICKS);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            COOLDOWN: begin
                if (move_tick) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = READY;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs; shield blinks on counter bit 2 during the final ticks
    always_comb begin
        shield_active  = (state_q == ACTIVE);
        shield_ready   = (state_q == READY);
        shield_visible = (state_q == ACTIVE) && ((cnt_q > CW'(BLINK_TICKS)) || cnt_q[2]);
    end

endmodule

// File: rtl/ship_sprite_controller.sv
// Player ship controller: position register, edge handling and registered pixel mux.
module ship_sprite_controller
    import starship_pkg::*;
#(
    parameter int H_ORIGIN       = 144,
    parameter int V_ORIGIN       = 35,
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int SHIP_W         = 64,
    parameter int SHIP_H         = 48,
    parameter int STEP           = 2,
    parameter int WRAP           = 0,
    parameter int SHIELD_W       = 8,
    parameter int SHIELD_GAP     = 2,
    parameter int SHIELD_TICKS   = 120,
    parameter int COOLDOWN_TICKS = 60,
    parameter int BLINK_TICKS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        bright,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        shield_req,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [11:0] rgb,
    output logic [9:0]  ship_x,
    output logic [9:0]  ship_y,
    output logic        shield_active,
    output logic        shield_ready
);

    localparam int XMAX = H_ACTIVE - SHIP_W;
    localparam int YMAX = V_ACTIVE - SHIP_H;

    // Pixel-region bounds in ship-relative coordinates
    localparam logic signed [11:0] BODY_W  = 12'(SHIP_W);
    localparam logic signed [11:0] BODY_H  = 12'(SHIP_H);
    localparam logic signed [11:0] WIN_X0  = 12'(SHIP_W / 4);
    localparam logic signed [11:0] WIN_X1  = 12'(3 * SHIP_W / 4);
    localparam logic signed [11:0] WIN_Y0  = 12'(SHIP_H / 6);
    localparam logic signed [11:0] WIN_Y1  = 12'(SHIP_H / 2);
    localparam logic signed [11:0] SHL_X0  = 12'(-SHIELD_GAP - SHIELD_W);
    localparam logic signed [11:0] SHL_X1  = 12'(-SHIELD_GAP);
    localparam logic signed [11:0] SHR_X0  = 12'(SHIP_W + SHIELD_GAP);
    localparam logic signed [11:0] SHR_X1  = 12'(SHIP_W + SHIELD_GAP + SHIELD_W);

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        shield_visible;

    // One axis step in 11-bit signed arithmetic, then saturate or wrap at the bounds
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                             input logic dec, input int lim);
        logic signed [10:0] nxt;
        logic [9:0]         res;
        nxt = $signed({1'b0, pos});
        if (inc && !dec) begin
            nxt = nxt + $signed(11'(STEP));
        end else if (dec && !inc) begin
            nxt = nxt - $signed(11'(STEP));
        end
        if (nxt < 0) begin
            res = (WRAP != 0) ? 10'(lim) : 10'd0;
        end else if (nxt > lim) begin
            res = (WRAP != 0) ? 10'd0 : 10'(lim);
        end else begin
            res = nxt[9:0];
        end
        return res;
    endfunction

    shield_fsm #(
        .SHIELD_TICKS  (SHIELD_TICKS),
        .COOLDOWN_TICKS(COOLDOWN_TICKS),
        .BLINK_TICKS   (BLINK_TICKS)
    ) u_shield_fsm (
        .clk           (clk),
        .rst           (rst),
        .move_tick     (move_tick),
        .shield_req    (shield_req),
        .shield_active (shield_active),
        .shield_ready  (shield_ready),
        .shield_visible(shield_visible)
    );

    // Position and pixel registers, centred on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= 10'((H_ACTIVE - SHIP_W) / 2);
            y_q   <= 10'((V_ACTIVE - SHIP_H) / 2);
            rgb_q <= BLACK;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            rgb_q <= rgb_d;
        end
    end

    // Movement: independent axes, only on move_tick
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (move_tick) begin
            x_d = step_axis(x_q, right, left, XMAX);
            y_d = step_axis(y_q, down, up, YMAX);
        end
    end

    // Pixel colour from raster position relative to the current (pre-update) ship position
    always_comb begin
        logic signed [11:0] px, py;
        logic               in_rows, in_body, in_window, in_shield;
        px = $signed({2'b00, hCount}) - $signed(12'(H_ORIGIN)) - $signed({2'b00, x_q});
        py = $signed({2'b00, vCount}) - $signed(12'(V_ORIGIN)) - $signed({2'b00, y_q});
        in_rows   = (py >= 0) && (py < BODY_H);
        in_body   = in_rows && (px >= 0) && (px < BODY_W);
        in_window = (px >= WIN_X0) && (px < WIN_X1) && (py >= WIN_Y0) && (py < WIN_Y1);
        in_shield = in_rows && (((px >= SHL_X0) && (px < SHL_X1)) ||
                                ((px >= SHR_X0) && (px < SHR_X1)));
        rgb_d = BACKGROUND;
        if (!bright) begin
            rgb_d = BLACK;
        end else if (shield_visible && in_shield) begin
            rgb_d = PINK;
        end else if (in_window) begin
            rgb_d = LIGHT_BLUE;
        end else if (in_body) begin
            rgb_d = GREY;
        end
    end

    assign rgb    = rgb_q;
    assign ship_x = x_q;
    assign ship_y = y_q;

endmodule

// File: tb/tb_ship_sprite_controller.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_ship_sprite_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_tick = 1'b0, bright = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, shield_req = 1'b0;
    logic [9:0] h_count = '0, v_count = '0;

    logic [11:0] rgb0, rgb1;
    logic [9:0]  x0, y0, x1, y1;
    logic        act0, rdy0, act1, rdy1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int x0, y0, x1, y1;
        bit act, rdy;
        int rgb0, rgb1;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int mx0, my0, mx1, my1;
    int m_phase;   // 0 ready, 1 shield on, 2 recharging
    int m_rem;     // move_ticks left in the current timed phase
    bit m_req_prev;

    always #5 clk = ~clk;

    ship_sprite_controller u_dut0 (
        .clk(clk), .rst(rst), .move_tick(move_tick), .bright(bright),
        .up(up), .down(down), .left(left), .right(right), .shield_req(shield_req),
        .hCount(h_count), .vCount(v_count), .rgb(rgb0), .ship_x(x0), .ship_y(y0),
        .shield_active(act0), .shield_ready(rdy0)
    );

    ship_sprite_controller #(.WRAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .move_tick(move_tick), .bright(bright),
        .up(up), .down(down), .left(left), .right(right), .shield_req(shield_req),
        .hCount(h_count), .vCount(v_count), .rgb(rgb1), .ship_x(x1), .ship_y(y1),
        .shield_active(act1), .shield_ready(rdy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int move_m(input int pos, input bit inc, input bit dec,
                                  input int lim, input bit wrap);
        int n;
        n = pos;
        if (inc && !dec) n = n + 2;
        if (dec && !inc) n = n - 2;
        if (n > lim) n = wrap ? 0 : lim;
        else if (n < 0) n = wrap ? lim : 0;
        return n;
    endfunction

    function automatic bit vis_m();
        return (m_phase == 1) && ((m_rem > 16) || (((m_rem >> 2) & 1) == 1));
    endfunction

    function automatic int colour_m(input int h, input int v, input bit b,
                                    input int x, input int y, input bit vis);
        int px, py;
        px = h - 144 - x;
        py = v - 35 - y;
        if (!b) return 'h000;
        if (vis && py >= 0 && py < 48 && ((px >= -10 && px < -2) || (px >= 66 && px < 74)))
            return 'hF88;
        if (px >= 16 && px < 48 && py >= 8 && py < 24) return 'h9DF;
        if (px >= 0 && px < 64 && py >= 0 && py < 48) return 'hCCC;
        return 'h015;
    endfunction

    task automatic model_reset();
        mx0 = 288; my0 = 216; mx1 = 288; my1 = 216;
        m_phase = 0; m_rem = 0; m_req_prev = 1'b0;
    endtask

    // One modelled clock: sample inputs at negedge, push expectation, release after posedge
    task automatic cyc();
        exp_t e;
        bit vis, edge_seen;
        @(negedge clk);
        vis = vis_m();
        e.rgb0 = colour_m(h_count, v_count, bright, mx0, my0, vis);
        e.rgb1 = colour_m(h_count, v_count, bright, mx1, my1, vis);
        if (move_tick) begin
            mx0 = move_m(mx0, right, left, 576, 1'b0);
            my0 = move_m(my0, down, up, 432, 1'b0);
            mx1 = move_m(mx1, right, left, 576, 1'b1);
            my1 = move_m(my1, down, up, 432, 1'b1);
        end
        edge_seen  = shield_req && !m_req_prev;
        m_req_prev = shield_req;
        if (m_phase == 0) begin
            if (edge_seen) begin
                m_phase = 1;
                m_rem   = 120;
            end
        end else if (move_tick) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_phase == 1) begin
                    m_phase = 2;
                    m_rem   = 60;
                end else begin
                    m_phase = 0;
                end
            end
        end
        e.x0 = mx0; e.y0 = my0; e.x1 = mx1; e.y1 = my1;
        e.act = (m_phase == 1);
        e.rdy = (m_phase == 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_reset_state();
        chk("rst_x0", x0, 288);
        chk("rst_y0", y0, 216);
        chk("rst_x1", x1, 288);
        chk("rst_y1", y1, 216);
        chk("rst_rgb0", rgb0, 0);
        chk("rst_rgb1", rgb1, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_active", act0, 0);
    endtask

    // Monitor: compare every presented output cycle against the scoreboard head
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_x0", x0, e.x0);
            chk("sb_y0", y0, e.y0);
            chk("sb_x1", x1, e.x1);
            chk("sb_y1", y1, e.y1);
            chk("sb_active0", act0, e.act);
            chk("sb_ready0", rdy0, e.rdy);
            chk("sb_active1", act1, e.act);
            chk("sb_ready1", rdy1, e.rdy);
            chk("sb_rgb0", rgb0, e.rgb0);
            chk("sb_rgb1", rgb1, e.rgb1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        #2;
        check_reset_state();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Pixel mux at the reset position
        bright = 1'b1;
        h_count = 10'd432; v_count = 10'd251; cyc(); settle(); chk("pix_body", rgb0, 'hCCC);
        h_count = 10'd464; v_count = 10'd260; cyc(); settle(); chk("pix_window", rgb0, 'h9DF);
        h_count = 10'd424; v_count = 10'd255; cyc(); settle(); chk("pix_no_shield", rgb0, 'h015);
        bright = 1'b0; cyc(); settle(); chk("pix_dark", rgb0, 'h000);

        // Raise the shield, then reset asynchronously from ACTIVE after moving
        bright = 1'b1;
        shield_req = 1'b1; cyc(); shield_req = 1'b0;
        cyc(); settle();
        chk("pix_shield", rgb0, 'hF88);
        chk("shield_on", act0, 1);
        right = 1'b1; move_tick = 1'b1;
        repeat (3) cyc();
        right = 1'b0; move_tick = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Movement with saturation
        right = 1'b1; move_tick = 1'b1;
        repeat (10) cyc();
        settle(); chk("move_x308", x0, 308); chk("move_y216", y0, 216);
        move_tick = 1'b0;
        repeat (5) cyc();
        settle(); chk("hold_x308", x0, 308);
        move_tick = 1'b1;
        repeat (150) cyc();
        settle(); chk("sat_x576", x0, 576);
        left = 1'b1;
        repeat (5) cyc();
        settle(); chk("lr_hold_x576", x0, 576);
        left = 1'b0;

        // Wrapping instance
        n = 0;
        while (mx1 != 576 && n < 400) begin cyc(); n++; end
        settle(); chk("wrap_reach_576", x1, 576);
        cyc(); settle(); chk("wrap_right_0", x1, 0);
        right = 1'b0; left = 1'b1;
        cyc(); settle(); chk("wrap_left_576", x1, 576);
        left = 1'b0; up = 1'b1;
        n = 0;
        while (my1 != 0 && n < 400) begin cyc(); n++; end
        settle(); chk("wrap_reach_y0", y1, 0);
        cyc(); settle(); chk("wrap_up_432", y1, 432);
        chk("sat_up_y0", y0, 0);
        up = 1'b0; move_tick = 1'b0;

        // Shield timing, raster parked on the left bar so blinking is observed
        h_count = 10'(144 + mx0 - 5);
        v_count = 10'(35 + my0 + 4);
        shield_req = 1'b1; cyc(); shield_req = 1'b0;
        settle(); chk("shield_start", act0, 1);
        move_tick = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            shield_req = (i == 50);
            cyc(); settle();
            if (i < 120) begin
                chk("shield_active_hold", act0, 1);
            end else begin
                chk("shield_end", act0, 0);
                chk("cooldown_start", rdy0, 0);
            end
        end
        shield_req = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            cyc(); settle();
            chk("cooldown_ready", rdy0, (i == 60) ? 1 : 0);
        end

        // Randomised traffic against the model
        repeat (1500) begin
            bit use1;
            move_tick  = ($urandom_range(0, 3) == 0);
            up         = $urandom_range(0, 1);
            down       = $urandom_range(0, 1);
            left       = $urandom_range(0, 1);
            right      = $urandom_range(0, 1);
            shield_req = ($urandom_range(0, 15) == 0);
            bright     = ($urandom_range(0, 7) != 0);
            use1       = $urandom_range(0, 1);
            h_count = 10'(144 + (use1 ? mx1 : mx0) + int'($urandom_range(0, 90)) - 15);
            v_count = 10'(35 + (use1 ? my1 : my0) + int'($urandom_range(0, 60)) - 6);
            cyc();
        end

        move_tick = 1'b0;
        cyc();
        #5;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
